// File: rtl/airi5c_regfile_gen.sv
// General-purpose register file with a scrub sequencer, optional write-to-read bypass, paired write and a debug port.
// Latency: reads are combinational; writes land on the rising edge; a scrub lasts NREGS cycles.
// Backpressure: none; while busy_o=1 all writes are dropped and reads return 0, so the caller must stall.
//
// Ports:
//   clk_i, rst_i        clock and synchronous active-high reset (reset starts a scrub)
//   init_req_i, busy_o  scrub request (taken only when idle) and scrub-in-progress flag
//   ra_i, rd_o          NRD packed read addresses / read data, port k at slice k
//   wen_i, wa_i, wd_i   pipeline write; wd2_i and use_rd64_i turn it into an even/odd pair write
//   dm_wara_i, dm_wd_i, dm_wen_i, dm_rd_o   debug-module access; its write wins over the pipeline write
module airi5c_regfile_gen #(
    parameter int XLEN = 32,
    parameter int NREGS = 32,
    parameter int NRD = 3,
    parameter int ZERO_REG = 1,
    parameter int BYPASS = 1,
    parameter logic [XLEN-1:0] INIT_VAL = '0,
    localparam int AW = $clog2(NREGS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                init_req_i,
    output logic                busy_o,
    input  logic [NRD*AW-1:0]   ra_i,
    output logic [NRD*XLEN-1:0] rd_o,
    input  logic                wen_i,
    input  logic [AW-1:0]       wa_i,
    input  logic [XLEN-1:0]     wd_i,
    input  logic [XLEN-1:0]     wd2_i,
    input  logic                use_rd64_i,
    input  logic [AW-1:0]       dm_wara_i,
    input  logic [XLEN-1:0]     dm_wd_i,
    input  logic                dm_wen_i,
    output logic [XLEN-1:0]     dm_rd_o
);

    localparam logic ZERO = (ZERO_REG != 0);
    localparam logic BYP  = (BYPASS != 0);

    typedef enum logic {IDLE, SCRUB} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   cnt;
    logic [AW-1:0]   cnt_nxt;
    logic            busy;
    logic            byp_en;
    logic [AW-1:0]   pair_even;
    logic [AW-1:0]   pair_odd;

    // No reset on the array so it can map onto FPGA block/distributed RAM.
    logic [XLEN-1:0] data [NREGS];

    // State register: reset always (re)starts a scrub from entry 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= SCRUB;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: init_req_i is only looked at in IDLE, so requests during a scrub are simply lost.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (init_req_i) begin
                    state_nxt = SCRUB;
                    cnt_nxt   = '0;
                end
            end
            SCRUB: begin
                if (cnt == AW'(NREGS - 1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + AW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output logic.
    always_comb begin
        busy = (state == SCRUB);
    end

    assign busy_o = busy;

    // Pair addresses are formed by masking bit 0, which also works for AW=1.
    assign pair_even = wa_i & ~AW'(1);
    assign pair_odd  = wa_i | AW'(1);

    // Only an undisturbed pipeline write is forwarded; a debug write in the same cycle kills it.
    assign byp_en = BYP && wen_i && !dm_wen_i && !busy;

    // Storage writes: scrub beats debug beats pipeline.
    always_ff @(posedge clk_i) begin
        if (busy) begin
            data[cnt] <= INIT_VAL;
        end else if (dm_wen_i) begin
            if (!(ZERO && dm_wara_i == '0)) begin
                data[dm_wara_i] <= dm_wd_i;
            end
        end else if (wen_i) begin
            if (use_rd64_i) begin
                if (!(ZERO && pair_even == '0)) begin
                    data[pair_even] <= wd_i;
                end
                data[pair_odd] <= wd2_i;
            end else if (!(ZERO && wa_i == '0)) begin
                data[wa_i] <= wd_i;
            end
        end
    end

    // Read ports: the zero/busy override is applied last so it also masks bypassed data.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] val;

        assign addr = ra_i[k*AW +: AW];

        always_comb begin
            val = data[addr];
            if (byp_en) begin
                if (use_rd64_i) begin
                    if (addr == pair_even) begin
                        val = wd_i;
                    end else if (addr == pair_odd) begin
                        val = wd2_i;
                    end
                end else if (addr == wa_i) begin
                    val = wd_i;
                end
            end
            if (busy || (ZERO && addr == '0)) begin
                val = '0;
            end
        end

        assign rd_o[k*XLEN +: XLEN] = val;
    end

    // Debug read never sees bypassed data.
    always_comb begin
        dm_rd_o = data[dm_wara_i];
        if (busy || (ZERO && dm_wara_i == '0)) begin
            dm_rd_o = '0;
        end
    end

endmodule

// File: tb/tb_airi5c_regfile_gen.sv
module tb_airi5c_regfile_gen;

    // Instance A: defaults (XLEN=32, NREGS=32, NRD=3, ZERO_REG=1, BYPASS=1, INIT_VAL=0).
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_req = 1'b0;
    logic        busy;
    logic [14:0] ra = '0;
    logic [95:0] rd;
    logic        wen = 1'b0;
    logic [4:0]  wa = '0;
    logic [31:0] wd = '0;
    logic [31:0] wd2 = '0;
    logic        rd64 = 1'b0;
    logic [4:0]  dm_a = '0;
    logic [31:0] dm_wd = '0;
    logic        dm_wen = 1'b0;
    logic [31:0] dm_rd;

    // Instance B: XLEN=64, NREGS=16, NRD=2, BYPASS=0, non-zero INIT_VAL.
    localparam logic [63:0] B_INIT = 64'h0123_4567_89AB_CDEF;
    logic         b_rst = 1'b1;
    logic         b_init_req = 1'b0;
    logic         b_busy;
    logic [7:0]   b_ra = '0;
    logic [127:0] b_rd;
    logic         b_wen = 1'b0;
    logic [3:0]   b_wa = '0;
    logic [63:0]  b_wd = '0;
    logic [63:0]  b_wd2 = '0;
    logic         b_rd64 = 1'b0;
    logic [3:0]   b_dm_a = '0;
    logic [63:0]  b_dm_wd = '0;
    logic         b_dm_wen = 1'b0;
    logic [63:0]  b_dm_rd;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    airi5c_regfile_gen u_dut (
        .clk_i(clk), .rst_i(rst), .init_req_i(init_req), .busy_o(busy),
        .ra_i(ra), .rd_o(rd), .wen_i(wen), .wa_i(wa), .wd_i(wd), .wd2_i(wd2),
        .use_rd64_i(rd64), .dm_wara_i(dm_a), .dm_wd_i(dm_wd), .dm_wen_i(dm_wen),
        .dm_rd_o(dm_rd)
    );

    airi5c_regfile_gen #(
        .XLEN(64), .NREGS(16), .NRD(2), .ZERO_REG(1), .BYPASS(0), .INIT_VAL(B_INIT)
    ) u_dut_b (
        .clk_i(clk), .rst_i(b_rst), .init_req_i(b_init_req), .busy_o(b_busy),
        .ra_i(b_ra), .rd_o(b_rd), .wen_i(b_wen), .wa_i(b_wa), .wd_i(b_wd), .wd2_i(b_wd2),
        .use_rd64_i(b_rd64), .dm_wara_i(b_dm_a), .dm_wd_i(b_dm_wd), .dm_wen_i(b_dm_wen),
        .dm_rd_o(b_dm_rd)
    );

    typedef struct {
        logic             wen;
        logic [4:0]       wa;
        logic [31:0]      wd;
        logic [31:0]      wd2;
        logic             rd64;
        logic             dm_wen;
        logic [4:0]       dm_a;
        logic [31:0]      dm_wd;
        logic [2:0][4:0]  ra;
        logic [2:0][31:0] exp;
        logic [31:0]      exp_dm;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input logic w, input logic [4:0] a, input logic [31:0] d,
                                input logic [31:0] d2, input logic p, input logic dw,
                                input logic [4:0] da, input logic [31:0] dd,
                                input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                                input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                                input logic [31:0] edm);
        vec_t v;
        v.wen = w; v.wa = a; v.wd = d; v.wd2 = d2; v.rd64 = p;
        v.dm_wen = dw; v.dm_a = da; v.dm_wd = dd;
        v.ra[0] = r0; v.ra[1] = r1; v.ra[2] = r2;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2;
        v.exp_dm = edm;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    initial begin
        int n;

        //           wen wa  wd            wd2           p  dw da  dm_wd         ra0 ra1 ra2  exp0          exp1          exp2          exp_dm
        vecs[0]  = mk(1, 5,  32'hCAFE0005, 32'h0,        0, 0, 5,  32'h0,        5,  5,  4,   32'hCAFE0005, 32'hCAFE0005, 32'h0,        32'h0);
        vecs[1]  = mk(0, 0,  32'h0,        32'h0,        0, 0, 5,  32'h0,        5,  0,  4,   32'hCAFE0005, 32'h0,        32'h0,        32'hCAFE0005);
        vecs[2]  = mk(1, 7,  32'h11111111, 32'h22222222, 1, 0, 7,  32'h0,        6,  7,  5,   32'h11111111, 32'h22222222, 32'hCAFE0005, 32'h0);
        vecs[3]  = mk(0, 0,  32'h0,        32'h0,        0, 0, 6,  32'h0,        6,  7,  0,   32'h11111111, 32'h22222222, 32'h0,        32'h11111111);
        vecs[4]  = mk(1, 0,  32'h33333333, 32'h44444444, 1, 0, 1,  32'h0,        0,  1,  6,   32'h0,        32'h44444444, 32'h11111111, 32'h0);
        vecs[5]  = mk(0, 0,  32'h0,        32'h0,        0, 0, 0,  32'h0,        0,  1,  2,   32'h0,        32'h44444444, 32'h0,        32'h0);
        vecs[6]  = mk(1, 3,  32'hBEEF0003, 32'h0,        0, 1, 3,  32'hDEAD0003, 3,  3,  5,   32'h0,        32'h0,        32'hCAFE0005, 32'h0);
        vecs[7]  = mk(0, 0,  32'h0,        32'h0,        0, 0, 3,  32'h0,        3,  2,  1,   32'hDEAD0003, 32'h0,        32'h44444444, 32'hDEAD0003);
        vecs[8]  = mk(1, 0,  32'hFFFFFFFF, 32'h0,        0, 0, 0,  32'h0,        0,  0,  0,   32'h0,        32'h0,        32'h0,        32'h0);
        vecs[9]  = mk(0, 0,  32'h0,        32'h0,        0, 1, 0,  32'h12345678, 0,  3,  7,   32'h0,        32'hDEAD0003, 32'h22222222, 32'h0);
        vecs[10] = mk(1, 31, 32'h0F0F0F0F, 32'h0,        0, 0, 0,  32'h0,        0,  31, 30,  32'h0,        32'h0F0F0F0F, 32'h0,        32'h0);
        vecs[11] = mk(1, 31, 32'hAAAAAAAA, 32'hBBBBBBBB, 1, 0, 31, 32'h0,        30, 31, 29,  32'hAAAAAAAA, 32'hBBBBBBBB, 32'h0,        32'h0F0F0F0F);
        vecs[12] = mk(0, 0,  32'h0,        32'h0,        0, 0, 30, 32'h0,        30, 31, 7,   32'hAAAAAAAA, 32'hBBBBBBBB, 32'h22222222, 32'hAAAAAAAA);
        vecs[13] = mk(1, 6,  32'h66666666, 32'h0,        0, 0, 7,  32'h0,        6,  7,  12,  32'h66666666, 32'h22222222, 32'h0,        32'h22222222);
        vecs[14] = mk(0, 0,  32'h0,        32'h0,        0, 0, 0,  32'h0,        6,  7,  1,   32'h66666666, 32'h22222222, 32'h44444444, 32'h0);

        // ---- A: reset then scrub, with writes attempted throughout ----
        @(posedge clk);
        #1;
        check("a_reset_busy", 64'(busy), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int c = 0; c < 100; c++) begin
            if (c > 0) @(negedge clk);
            wen = 1'b1; wa = 5'd2; wd = 32'hBAD0BAD0;
            dm_wen = 1'b1; dm_a = 5'd4; dm_wd = 32'hBAD1BAD1;
            #1;
            if (!busy) break;
            n++;
        end
        wen = 1'b0; dm_wen = 1'b0;
        check("a_scrub_len", 64'(n), 64'd32);
        ra = {5'd31, 5'd4, 5'd2}; dm_a = 5'd4;
        #1;
        check("a_post_scrub_x2", 64'(rd[31:0]), 64'h0);
        check("a_post_scrub_x4", 64'(rd[63:32]), 64'h0);
        check("a_post_scrub_x31", 64'(rd[95:64]), 64'h0);
        check("a_post_scrub_dm_x4", 64'(dm_rd), 64'h0);

        // ---- A: table-driven vectors ----
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            wen = vecs[i].wen; wa = vecs[i].wa; wd = vecs[i].wd; wd2 = vecs[i].wd2;
            rd64 = vecs[i].rd64; dm_wen = vecs[i].dm_wen; dm_a = vecs[i].dm_a;
            dm_wd = vecs[i].dm_wd; ra = vecs[i].ra;
            #1;
            for (int k = 0; k < 3; k++) begin
                check($sformatf("vec%0d_rd%0d", i, k), 64'(rd[k*32 +: 32]), 64'(vecs[i].exp[k]));
            end
            check($sformatf("vec%0d_dm", i), 64'(dm_rd), 64'(vecs[i].exp_dm));
        end

        // ---- A: init request, busy masking, reset mid-scrub, ignored init_req ----
        @(negedge clk);
        rd64 = 1'b0; dm_wen = 1'b0;
        wen = 1'b1; wa = 5'd20; wd = 32'h5A5A5A5A; ra = {5'd0, 5'd0, 5'd20};
        #1;
        check("a_x20_bypass", 64'(rd[31:0]), 64'h5A5A5A5A);
        @(negedge clk);
        wen = 1'b0; init_req = 1'b1; dm_a = 5'd20;
        #1;
        check("a_x20_stored", 64'(rd[31:0]), 64'h5A5A5A5A);
        check("a_x20_dm", 64'(dm_rd), 64'h5A5A5A5A);
        @(negedge clk);
        init_req = 1'b0;
        #1;
        check("a_init_busy", 64'(busy), 64'd1);
        check("a_busy_rd_zero", 64'(rd[31:0]), 64'h0);
        check("a_busy_dm_zero", 64'(dm_rd), 64'h0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int c = 0; c < 100; c++) begin
            if (c > 0) @(negedge clk);
            init_req = 1'b0;
            #1;
            if (!busy) break;
            n++;
            if (n == 21) init_req = 1'b1;
        end
        init_req = 1'b0;
        check("a_midscrub_len", 64'(n), 64'd32);
        ra = {5'd7, 5'd5, 5'd20};
        #1;
        check("a_rescrub_x20", 64'(rd[31:0]), 64'h0);
        check("a_rescrub_x5", 64'(rd[63:32]), 64'h0);
        check("a_rescrub_x7", 64'(rd[95:64]), 64'h0);

        // ---- B: 64-bit, 16 registers, 2 ports, no bypass ----
        @(negedge clk);
        b_rst = 1'b0;
        n = 0;
        for (int c = 0; c < 100; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (!b_busy) break;
            n++;
        end
        check("b_scrub_len", 64'(n), 64'd16);
        b_ra = {4'd0, 4'd9}; b_dm_a = 4'd0;
        #1;
        check("b_init_x9", b_rd[63:0], B_INIT);
        check("b_x0_port1", b_rd[127:64], 64'h0);
        check("b_x0_dm", b_dm_rd, 64'h0);
        @(negedge clk);
        b_wen = 1'b1; b_wa = 4'd5; b_wd = 64'hCAFE0005_00000005; b_ra = {4'd0, 4'd5};
        #1;
        check("b_nobypass_old", b_rd[63:0], B_INIT);
        @(negedge clk);
        b_wen = 1'b0;
        #1;
        check("b_nobypass_new", b_rd[63:0], 64'hCAFE0005_00000005);
        @(negedge clk);
        b_wen = 1'b1; b_rd64 = 1'b1; b_wa = 4'd3;
        b_wd = 64'h11111111_11111111; b_wd2 = 64'h22222222_22222222;
        @(negedge clk);
        b_wa = 4'd1; b_wd = 64'h33333333_33333333; b_wd2 = 64'h44444444_44444444;
        b_ra = {4'd3, 4'd2};
        #1;
        check("b_pair_even", b_rd[63:0], 64'h11111111_11111111);
        check("b_pair_odd", b_rd[127:64], 64'h22222222_22222222);
        @(negedge clk);
        b_rd64 = 1'b0; b_wa = 4'd3; b_wd = 64'hBEEF0003_BEEF0003;
        b_dm_wen = 1'b1; b_dm_a = 4'd3; b_dm_wd = 64'hDEAD0003_DEAD0003;
        b_ra = {4'd0, 4'd1};
        #1;
        check("b_pair0_x1", b_rd[63:0], 64'h44444444_44444444);
        check("b_pair0_x0", b_rd[127:64], 64'h0);
        @(negedge clk);
        b_wen = 1'b0; b_dm_wen = 1'b0; b_ra = {4'd0, 4'd3};
        #1;
        check("b_prio_x3", b_rd[63:0], 64'hDEAD0003_DEAD0003);
        check("b_prio_dm_x3", b_dm_rd, 64'hDEAD0003_DEAD0003);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
